clkgate_bank_rf: RTL and testbench

- Parametrised successor to the single-gate clock-gated register file.
- Storage is split into NUM_BANKS banks. Each bank has its own latch-based ICG, so a write clocks only the bank it hits.
- An always-on controller gates the read path automatically after IDLE_CYC idle cycles, with a req/ready handshake and a one-cycle wake.
- Sits between a bus-side requester and low-activity configuration/lookup storage in low-power subsystems.

---
 rtl/clkgate_bank_rf.sv | 239 +++++++++++++++++++++++
 tb/tb_clkgate_bank_rf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgate_bank_rf.sv
// -----------------------------------------------------------------------------
// clkgate_bank_rf
//   Banked, clock-gated register file for low-activity configuration/lookup
//   storage. Each bank has its own latch-based ICG so a write clocks only the
//   bank it targets. The read path (q) sits behind a global ICG that an
//   always-on controller closes after IDLE_CYC idle cycles (SLEEP). A request
//   arriving in SLEEP takes one WAKE cycle before it is accepted.
//
// Ports
//   clk          in   free-running clock (controller and ICG latches)
//   rst          in   asynchronous reset, active-high
//   clken        in   global enable; 0 gates the block and drops ready
//   test_en      in   scan override; forces every ICG open
//   req          in   access request, held until accepted
//   wr_en        in   1 = write, 0 = read (qualified by req)
//   addr         in   entry address [ADDR_W-1:0]
//   data         in   write data [DATA_W-1:0]
//   ready        out  a request can be accepted this cycle
//   q            out  read data register [DATA_W-1:0]
//   q_vld        out  one-cycle pulse when q is updated
//   sleep        out  controller is in SLEEP
//   bank_clk_on  out  latched per-bank ICG enables [NUM_BANKS-1:0]
// -----------------------------------------------------------------------------
module clkgate_bank_rf #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int NUM_BANKS = 4,
  parameter int IDLE_CYC  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 test_en,
  input  logic                 req,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data,
  output logic                 ready,
  output logic [DATA_W-1:0]    q,
  output logic                 q_vld,
  output logic                 sleep,
  output logic [NUM_BANKS-1:0] bank_clk_on
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int EPB    = DEPTH / NUM_BANKS;             // entries per bank
  localparam int SHIFT  = $clog2(EPB);                   // offset bits
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int OFF_W  = (EPB > 1) ? $clog2(EPB) : 1;
  localparam int CNT_W  = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_IDLE_CNT,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_acc;
  logic               w_rd_stb;
  logic               w_glb_en;
  logic [NUM_BANKS-1:0] w_bank_wr;
  logic [NUM_BANKS-1:0] w_bank_en;
  logic [BANK_W-1:0]  w_bank_idx;
  logic [OFF_W-1:0]   w_off;

  // ICG latch outputs: enables plus the strobes that qualify what the gated
  // flops do once their clock ticks (test_en opens clocks but must not write).
  logic               r_glb_en;
  logic               r_rd_stb;
  logic [NUM_BANKS-1:0] r_bank_en;
  logic [NUM_BANKS-1:0] r_bank_wr;

  logic               w_gclk;
  logic [NUM_BANKS-1:0] w_bank_gclk;
  logic [DATA_W-1:0]  w_bank_rd [NUM_BANKS];

  logic [DATA_W-1:0]  r_q;
  logic               r_q_vld;

  // ---------------------------------------------------------------------------
  // Address decode: bank = top address bits, offset = remaining low bits.
  // ---------------------------------------------------------------------------
  assign w_bank_idx = (NUM_BANKS > 1) ? BANK_W'(addr >> SHIFT) : '0;
  assign w_off      = (EPB > 1) ? OFF_W'(addr) : '0;

  assign w_acc    = req & ready;
  assign w_rd_stb = w_acc & ~wr_en;
  assign w_glb_en = test_en | (clken & (r_state != ST_SLEEP));

  always_comb begin
    w_bank_wr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_wr[b] = w_acc & wr_en & (w_bank_idx == BANK_W'(b));
    end
  end

  assign w_bank_en = {NUM_BANKS{test_en}} | w_bank_wr;

  // ---------------------------------------------------------------------------
  // ICG enable latches, transparent while clk is low. Anything that changes
  // during the clk-high phase is held off until the next low phase, so a
  // gated clock can never be cut short or pulsed twice.
  // NOTE: this is a deliberate level-sensitive latch; always_latch documents
  // the intent, where an incomplete always_comb would infer the same thing by
  // accident.
  // ---------------------------------------------------------------------------
  always_latch begin
    if (rst) begin
      r_glb_en  <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_bank_en <= '0;
      r_bank_wr <= '0;
    end else if (!clk) begin
      r_glb_en  <= w_glb_en;
      r_rd_stb  <= w_rd_stb;
      r_bank_en <= w_bank_en;
      r_bank_wr <= w_bank_wr;
    end
  end

  assign w_gclk      = clk & r_glb_en;
  assign w_bank_gclk = {NUM_BANKS{clk}} & r_bank_en;
  assign bank_clk_on = r_bank_en;

  // ---------------------------------------------------------------------------
  // Storage banks, each on its own gated clock.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [EPB];

    // NOTE: the storage is cleared by the asynchronous reset because the
    // design promises all-zero contents after reset; a memory without that
    // requirement would normally be left unreset so it can map to RAM.
    always_ff @(posedge w_bank_gclk[b] or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < EPB; i++) begin
          r_mem[i] <= '0;
        end
      end else if (r_bank_wr[b]) begin
        r_mem[w_off] <= data;
      end
    end

    assign w_bank_rd[b] = r_mem[w_off];
  end

  // ---------------------------------------------------------------------------
  // Read data register on the global gated clock; holds through SLEEP.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_gclk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (r_rd_stb) begin
      r_q <= w_bank_rd[w_bank_idx];
    end
  end

  // q_vld runs on the free clock so the pulse always clears, even if the
  // global ICG closes in the cycle right after a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_vld <= 1'b0;
    end else begin
      r_q_vld <= w_rd_stb;
    end
  end

  assign q     = r_q;
  assign q_vld = r_q_vld;

  // ---------------------------------------------------------------------------
  // Power controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACTIVE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Power controller: next state. With clken low everything holds except
  // WAKE, which always completes so a woken requester is not stranded.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ACTIVE: begin
        if (clken && !w_acc && (IDLE_CYC != 0)) begin
          w_state_nxt = ST_IDLE_CNT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_IDLE_CNT: begin
        if (clken) begin
          if (w_acc) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(IDLE_CYC)) begin
            w_state_nxt = ST_SLEEP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_SLEEP: begin
        if (req && clken) begin
          w_state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        w_state_nxt = ST_ACTIVE;
      end
      default: begin
        w_state_nxt = ST_ACTIVE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Power controller: outputs. ready is masked by rst so nothing is accepted
  // while the block is held in reset.
  always_comb begin
    ready = clken & ~rst & ((r_state == ST_ACTIVE) || (r_state == ST_IDLE_CNT));
    sleep = (r_state == ST_SLEEP);
  end

endmodule

// File: tb/tb_clkgate_bank_rf.sv
// -----------------------------------------------------------------------------
// tb_clkgate_bank_rf
//   Directed self-checking bench for clkgate_bank_rf (default parameters:
//   DATA_W=8, ADDR_W=4, NUM_BANKS=4, IDLE_CYC=8). Expected values are written
//   by hand next to each stimulus. Gated-clock edges are counted by probing
//   the ICG outputs inside the design.
// -----------------------------------------------------------------------------
module tb_clkgate_bank_rf;

  logic       clk = 1'b1;
  logic       rst;
  logic       clken;
  logic       test_en;
  logic       req;
  logic       wr_en;
  logic [3:0] addr;
  logic [7:0] data;
  logic       ready;
  logic [7:0] q;
  logic       q_vld;
  logic       sleep;
  logic [3:0] bank_clk_on;

  int n_vec = 0;
  int n_err = 0;
  int n_gclk = 0;
  int n_bclk0 = 0;
  int n_bclk1 = 0;
  int n_bclk2 = 0;
  int n_bclk3 = 0;
  int waits;

  clkgate_bank_rf #(
    .DATA_W   (8),
    .ADDR_W   (4),
    .NUM_BANKS(4),
    .IDLE_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .test_en    (test_en),
    .req        (req),
    .wr_en      (wr_en),
    .addr       (addr),
    .data       (data),
    .ready      (ready),
    .q          (q),
    .q_vld      (q_vld),
    .sleep      (sleep),
    .bank_clk_on(bank_clk_on)
  );

  // Rising edges at 10, 20, 30 ... ns; clk is high for the first 5 ns of each.
  always #5 clk = ~clk;

  always @(posedge dut.w_gclk)         n_gclk++;
  always @(posedge dut.w_bank_gclk[0]) n_bclk0++;
  always @(posedge dut.w_bank_gclk[1]) n_bclk1++;
  always @(posedge dut.w_bank_gclk[2]) n_bclk2++;
  always @(posedge dut.w_bank_gclk[3]) n_bclk3++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_edges();
    n_gclk  = 0;
    n_bclk0 = 0;
    n_bclk1 = 0;
    n_bclk2 = 0;
    n_bclk3 = 0;
  endtask

  // Raise a request and hold it until it is accepted. Returns 1 ns after the
  // acceptance edge with junk on the qualified inputs and req low.
  task automatic do_acc(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        output int w);
    req   = 1'b1;
    wr_en = wr;
    addr  = a;
    data  = d;
    w     = 0;
    while (!ready && w < 20) begin
      tick();
      w++;
    end
    if (!ready) begin
      check("acc_timeout", 32'd0, 32'd1);
    end else begin
      tick();
    end
    req   = 1'b0;
    wr_en = 1'b1;
    addr  = ~a;
    data  = 8'hFF;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    int w;
    do_acc(1'b0, a, 8'h00, w);
    check({tag, "_q"}, 32'(q), 32'(exp));
    check({tag, "_vld"}, 32'(q_vld), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clken = 1'b1; test_en = 1'b0;
    req = 1'b0; wr_en = 1'b0; addr = '0; data = '0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_qvld", 32'(q_vld), 32'd0);
    check("rst_sleep", 32'(sleep), 32'd0);
    check("rst_bank_on", 32'(bank_clk_on), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(ready), 32'd1);

    // ---- 1: write 0x31..0x39 to addr 3..11, read back ----
    for (int i = 0; i < 9; i++) begin
      do_acc(1'b1, 4'(3 + i), 8'(8'h31 + i), waits);
    end
    for (int i = 0; i < 9; i++) begin
      rd_chk($sformatf("rd%0d", 3 + i), 4'(3 + i), 8'(8'h31 + i));
    end
    tick();
    check("qvld_pulse", 32'(q_vld), 32'd0);
    check("q_hold", 32'(q), 32'h39);

    // ---- 2: write addr 5 clocks only bank 1 ----
    clr_edges();
    do_acc(1'b1, 4'h5, 8'hA5, waits);
    check("bank_on_wr5", 32'(bank_clk_on), 32'b0010);
    tick();
    check("bank_on_idle", 32'(bank_clk_on), 32'd0);
    check("bclk0", 32'(n_bclk0), 32'd0);
    check("bclk1", 32'(n_bclk1), 32'd1);
    check("bclk2", 32'(n_bclk2), 32'd0);
    check("bclk3", 32'(n_bclk3), 32'd0);
    rd_chk("rd5_new", 4'h5, 8'hA5);

    // ---- 3: auto-sleep and wake ----
    for (int i = 0; i < 7; i++) tick();
    check("awake_7idle", 32'(sleep), 32'd0);
    tick();
    tick();
    check("sleep_9idle", 32'(sleep), 32'd1);
    check("sleep_ready", 32'(ready), 32'd0);
    do_acc(1'b0, 4'h3, 8'h00, waits);
    check("wake_waits", 32'(waits), 32'd2);
    check("wake_q", 32'(q), 32'h31);
    check("wake_qvld", 32'(q_vld), 32'd1);

    // ---- 4: clken glitches inside clk-high phase ----
    clr_edges();
    for (int i = 0; i < 4; i++) begin
      #1 clken = 1'b0;
      #1 clken = 1'b1;
      tick();
    end
    check("glitch_gclk", 32'(n_gclk), 32'd4);
    check("glitch_bclk", 32'(n_bclk0 + n_bclk1 + n_bclk2 + n_bclk3), 32'd0);
    check("glitch_q", 32'(q), 32'h31);
    check("glitch_qvld", 32'(q_vld), 32'd0);
    rd_chk("rd11", 4'hB, 8'h39);

    // ---- 5: test_en with clken low ----
    clken = 1'b0;
    test_en = 1'b1;
    req = 1'b1; wr_en = 1'b1; addr = 4'h3; data = 8'hEE;
    #1;
    check("scan_ready0", 32'(ready), 32'd0);
    tick();
    check("scan_bank_on", 32'(bank_clk_on), 32'hF);
    tick();
    check("scan_ready1", 32'(ready), 32'd0);
    check("scan_q", 32'(q), 32'h39);
    check("scan_qvld", 32'(q_vld), 32'd0);
    req = 1'b0; test_en = 1'b0; clken = 1'b1;
    rd_chk("scan_rd3", 4'h3, 8'h31);

    // ---- 6a: reset during a write to addr 4 ----
    req = 1'b1; wr_en = 1'b1; addr = 4'h4; data = 8'h77;
    #5 rst = 1'b1;
    #1;
    check("rstw_bank_on", 32'(bank_clk_on), 32'd0);
    check("rstw_ready", 32'(ready), 32'd0);
    check("rstw_q", 32'(q), 32'd0);
    check("rstw_qvld", 32'(q_vld), 32'd0);
    tick();
    req = 1'b0;
    rst = 1'b0;
    tick();
    check("rstw_ready_rel", 32'(ready), 32'd1);
    check("rstw_sleep", 32'(sleep), 32'd0);
    rd_chk("rstw_rd4", 4'h4, 8'h00);
    rd_chk("rstw_rd3", 4'h3, 8'h00);

    // ---- 6b: reset during WAKE ----
    do_acc(1'b1, 4'h9, 8'h5A, waits);
    rd_chk("rd9", 4'h9, 8'h5A);
    for (int i = 0; i < 10; i++) tick();
    check("rstk_sleep", 32'(sleep), 32'd1);
    req = 1'b1; wr_en = 1'b0; addr = 4'h3;
    tick();
    check("rstk_wake_sleep", 32'(sleep), 32'd0);
    check("rstk_wake_ready", 32'(ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rstk_q", 32'(q), 32'd0);
    tick();
    req = 1'b0;
    rst = 1'b0;
    #1;
    check("rstk_ready_rel", 32'(ready), 32'd1);
    tick();
    check("rstk_ready", 32'(ready), 32'd1);
    check("rstk_qvld", 32'(q_vld), 32'd0);
    check("rstk_q_after", 32'(q), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
